// File: rtl/dram_cmd_bus_arbiter_pkg.sv
// Shared types for the DRAM command bus arbiter: command encoding and bank-index sizing.
package dram_cmd_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_e;

  localparam int DEFAULT_NUM_BANKS = 4;
  localparam int BANK_IDX_W        = $clog2(DEFAULT_NUM_BANKS);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_cmd_bus_arbiter_rr_arbiter.sv
// Round-robin pick among eligible banks, searching upward from the bank after last_grant.
module dram_cmd_bus_arbiter_rr_arbiter
  import dram_cmd_bus_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
  parameter int IDX_W     = BANK_IDX_W
) (
  input  logic [NUM_BANKS-1:0] eligible,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_BANKS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_any
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Rotating first-eligible search; the wrap ends on last_grant itself.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int off = 1; off <= NUM_BANKS; off++) begin
      cand_s        = IDX_W'((int'(last_grant) + off) % NUM_BANKS);
      hit_s         = eligible[cand_s] & ~grant_any;
      grant[cand_s] = hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      grant_any     = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/dram_cmd_bus_arbiter.sv
// DRAM command bus arbiter: round-robin bank grant with tRRD/tCCD spacing into a one-entry output slot.
// Optional DRAM_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module dram_cmd_bus_arbiter
  import dram_cmd_bus_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
  parameter int ADDR_W    = 16,
  parameter int TRRD      = 4,
  parameter int TCCD      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BANKS-1:0]         req_valid,
  input  logic [2*NUM_BANKS-1:0]       req_cmd,
  input  logic [ADDR_W*NUM_BANKS-1:0]  req_addr,
  output logic [NUM_BANKS-1:0]         req_ready,
  output logic                         out_valid,
  output logic [1:0]                   out_cmd,
  output logic [$clog2(NUM_BANKS)-1:0] out_bank,
  output logic [ADDR_W-1:0]            out_addr,
  input  logic                         out_ready
`ifdef DRAM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int IDX_W  = idx_width(NUM_BANKS);
  localparam int TRRD_W = $clog2(TRRD + 1);
  localparam int TCCD_W = $clog2(TCCD + 1);

  logic [TRRD_W-1:0]    trrd_cnt_r;
  logic [TCCD_W-1:0]    tccd_cnt_r;
  logic [IDX_W-1:0]     last_grant_r;
  logic [NUM_BANKS-1:0] elig_s;
  logic [NUM_BANKS-1:0] grant_vec_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic                 grant_any_s;
  logic                 slot_free_s;
  logic                 grant_en_s;
  logic [1:0]           win_cmd_s;
  logic [ADDR_W-1:0]    win_addr_s;
  logic                 act_grant_s;
  logic                 col_grant_s;

  // Per-bank eligibility from the command type and the spacing counters.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      case (cmd_e'(req_cmd[2*i +: 2]))
        CMD_ACT: elig_s[i] = req_valid[i] && (trrd_cnt_r == '0);
        CMD_RD:  elig_s[i] = req_valid[i] && (tccd_cnt_r == '0);
        CMD_WR:  elig_s[i] = req_valid[i] && (tccd_cnt_r == '0);
        CMD_PRE: elig_s[i] = req_valid[i];
        default: elig_s[i] = 1'b0;
      endcase
    end
  end

  dram_cmd_bus_arbiter_rr_arbiter #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .eligible   (elig_s),
    .last_grant (last_grant_r),
    .grant      (grant_vec_s),
    .grant_idx  (grant_idx_s),
    .grant_any  (grant_any_s)
  );

  // One-hot AND-OR select of the winning bank's command and address.
  always_comb begin
    win_cmd_s  = 2'd0;
    win_addr_s = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      win_cmd_s  = win_cmd_s  | ({2{grant_vec_s[i]}} & req_cmd[2*i +: 2]);
      win_addr_s = win_addr_s | ({ADDR_W{grant_vec_s[i]}} & req_addr[ADDR_W*i +: ADDR_W]);
    end
  end

  // A drain and a new grant in the same cycle refill the slot without a bubble.
  assign slot_free_s = !out_valid || out_ready;
  assign grant_en_s  = slot_free_s && grant_any_s;
  assign req_ready   = grant_en_s ? grant_vec_s : '0;
  assign act_grant_s = grant_en_s && (win_cmd_s == CMD_ACT);
  assign col_grant_s = grant_en_s && ((win_cmd_s == CMD_RD) || (win_cmd_s == CMD_WR));

  // Output slot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cmd   <= 2'd0;
      out_bank  <= '0;
      out_addr  <= '0;
    end else if (grant_en_s) begin
      out_valid <= 1'b1;
      out_cmd   <= win_cmd_s;
      out_bank  <= grant_idx_s;
      out_addr  <= win_addr_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer; reset value gives bank 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= IDX_W'(NUM_BANKS - 1);
    end else if (grant_en_s) begin
      last_grant_r <= grant_idx_s;
    end
  end

  // ACT-to-ACT spacing counter, saturating at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trrd_cnt_r <= '0;
    end else if (act_grant_s) begin
      trrd_cnt_r <= TRRD_W'(TRRD - 1);
    end else if (trrd_cnt_r != '0) begin
      trrd_cnt_r <= trrd_cnt_r - TRRD_W'(1);
    end
  end

  // Column-to-column spacing counter, saturating at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tccd_cnt_r <= '0;
    end else if (col_grant_s) begin
      tccd_cnt_r <= TCCD_W'(TCCD - 1);
    end else if (tccd_cnt_r != '0) begin
      tccd_cnt_r <= tccd_cnt_r - TCCD_W'(1);
    end
  end

`ifdef DRAM_ARB_STALL_CNT_EN
  // Counts cycles with a pending request that did not receive a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if ((|req_valid) && !grant_en_s && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_cmd_bus_arbiter.sv
// Scoreboard bench for dram_cmd_bus_arbiter: expected grants queued at stimulus time, checked at grant and at drain.
`timescale 1ns/1ps
module tb_dram_cmd_bus_arbiter;
  import dram_cmd_bus_arbiter_pkg::*;

  localparam int NB   = 4;
  localparam int AW   = 16;
  localparam int TRRD = 4;
  localparam int TCCD = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   req_valid;
  logic [2*NB-1:0] req_cmd;
  logic [AW*NB-1:0] req_addr;
  logic [NB-1:0]   req_ready;
  logic            out_valid;
  logic [1:0]      out_cmd;
  logic [1:0]      out_bank;
  logic [AW-1:0]   out_addr;
  logic            out_ready;
`ifdef DRAM_ARB_STALL_CNT_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     stall_base;
`endif

  dram_cmd_bus_arbiter #(
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .TRRD      (TRRD),
    .TCCD      (TCCD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_cmd   (out_cmd),
    .out_bank  (out_bank),
    .out_addr  (out_addr),
    .out_ready (out_ready)
`ifdef DRAM_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    cmd;
    int            bank;
    logic [AW-1:0] addr;
    int            gcyc;
    int            xcyc;
  } exp_t;

  exp_t          gq[$];
  exp_t          oq[$];
  logic [1:0]    lcmd  [NB][8];
  logic [AW-1:0] laddr [NB][8];
  int            lcnt  [NB];
  int            lptr  [NB];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NB; i++) begin
      if (lptr[i] < lcnt[i]) begin
        req_valid[i]          = 1'b1;
        req_cmd[2*i +: 2]     = lcmd[i][lptr[i]];
        req_addr[AW*i +: AW]  = laddr[i][lptr[i]];
      end else begin
        req_valid[i]          = 1'b0;
        req_cmd[2*i +: 2]     = 2'd0;
        req_addr[AW*i +: AW]  = '0;
      end
    end
  endtask

  task automatic clear_lists();
    for (int i = 0; i < NB; i++) begin
      lcnt[i] = 0;
      lptr[i] = 0;
    end
  endtask

  // Queue a request for bank b and the grant/drain cycles it is expected at (offsets from now).
  task automatic add(input int b, input logic [1:0] cmd, input logic [AW-1:0] addr,
                     input int goff, input int xoff);
    exp_t e;
    lcmd[b][lcnt[b]]  = cmd;
    laddr[b][lcnt[b]] = addr;
    lcnt[b]++;
    e.cmd  = cmd;
    e.bank = b;
    e.addr = addr;
    e.gcyc = cyc + goff;
    e.xcyc = cyc + xoff;
    gq.push_back(e);
  endtask

  task automatic step();
    logic [NB-1:0] gnt;
    exp_t          e;
    int            gb;
    @(negedge clk);
    chk("onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (out_valid && !out_ready && oq.size() > 0) begin
      chk("hold_cmd",   32'(out_cmd),  32'(oq[0].cmd));
      chk("hold_bank",  32'(out_bank), oq[0].bank);
      chk("hold_addr",  32'(out_addr), 32'(oq[0].addr));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    if (out_valid && out_ready) begin
      if (oq.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = oq.pop_front();
        chk("out_cmd",  32'(out_cmd),  32'(e.cmd));
        chk("out_bank", 32'(out_bank), e.bank);
        chk("out_addr", 32'(out_addr), 32'(e.addr));
        chk("out_cyc",  cyc, e.xcyc);
      end
    end
    if (req_ready != '0) begin
      if (gq.size() == 0) begin
        chk("spurious_grant", 32'(req_ready), 32'd0);
      end else begin
        e  = gq.pop_front();
        gb = 0;
        for (int i = 0; i < NB; i++) if (req_ready[i]) gb = i;
        chk("grant_bank", gb, e.bank);
        chk("grant_cyc",  cyc, e.gcyc);
        oq.push_back(e);
      end
    end
    gnt = req_ready;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NB; i++) if (gnt[i]) lptr[i]++;
    drive();
  endtask

  task automatic run(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (gq.size() == 0 && oq.size() == 0) break;
      step();
    end
    chk("drain", gq.size() + oq.size(), 32'd0);
  endtask

  initial begin
    int t0;
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_cmd   = '0;
    req_addr  = '0;
    clear_lists();
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cmd",   32'(out_cmd),   32'd0);
    chk("rst_bank",  32'(out_bank),  32'd0);
    chk("rst_addr",  32'(out_addr),  32'd0);
`ifdef DRAM_ARB_STALL_CNT_EN
    chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    rst = 1'b0;
    step();
    step();

    // All banks stream RD: tCCD spaces grants two cycles apart in round-robin order.
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < NB; b++)
        add(b, CMD_RD, AW'(32'h1000 + b * 16 + k), 8 * k + 2 * b, 8 * k + 2 * b + 1);
    drive();
    run(40);

    // ACT on bank 0, PRE slips in next cycle, bank 1 ACT waits out tRRD.
    add(0, CMD_ACT, 16'h0A00, 0, 1);
    add(2, CMD_PRE, 16'h0C00, 1, 2);
    add(1, CMD_ACT, 16'h0B00, TRRD, TRRD + 1);
    drive();
    run(20);

    // Consumer stalls 5 cycles; slot holds, then drain and refill in one cycle.
    add(0, CMD_PRE, 16'h3000, 0, 6);
    add(1, CMD_PRE, 16'h3100, 6, 7);
    drive();
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      out_ready = ((cyc - t0) >= 1 && (cyc - t0) <= 5) ? 1'b0 : 1'b1;
      step();
    end
    out_ready = 1'b1;
    run(5);

    // Single requester alternating column/precharge commands; back-to-back WR blocked one cycle.
    add(3, CMD_WR,  16'h4001, 0, 1);
    add(3, CMD_PRE, 16'h4002, 1, 2);
    add(3, CMD_WR,  16'h4003, 2, 3);
    add(3, CMD_WR,  16'h4004, 4, 5);
    drive();
    run(20);

    // Reset with a full slot, then the pointer restarts at bank 0.
    add(2, CMD_PRE, 16'h5000, 0, 1);
    drive();
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    clear_lists();
    drive();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cmd",   32'(out_cmd),   32'd0);
    chk("mid_rst_bank",  32'(out_bank),  32'd0);
    chk("mid_rst_addr",  32'(out_addr),  32'd0);
`ifdef DRAM_ARB_STALL_CNT_EN
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
`endif
    oq.delete();
    gq.delete();
    step();
    step();
    rst = 1'b0;
    add(0, CMD_PRE, 16'h5100, 0, 1);
    add(1, CMD_PRE, 16'h5200, 1, 2);
    add(3, CMD_PRE, 16'h5300, 2, 3);
    drive();
    run(20);

`ifdef DRAM_ARB_STALL_CNT_EN
    // One bank holds its second ACT through the tRRD window.
    stall_base = stall_cnt;
    add(0, CMD_ACT, 16'h6000, 0, 1);
    add(0, CMD_ACT, 16'h6001, TRRD, TRRD + 1);
    drive();
    run(20);
    chk("stall_delta", 32'(stall_cnt - stall_base), 32'(TRRD - 1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
